// File: rtl/pipe_if_stage.sv
// Instruction-fetch stage: PC, next-PC select, req/ack fetch FSM and IF/ID register.
// Optional performance counters are enabled with `define PIPE_IF_PERF_EN.
module pipe_if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wpcir,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] dpc4,
  output logic [31:0] dinst,
  output logic        dvalid,
  output logic        fetch_busy,
`ifdef PIPE_IF_PERF_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_squash,
`endif
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_e;

  // Handshake: imem_req stays high from issue until the cycle imem_ack is
  // sampled high; imem_addr is constant over that whole window.
  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] dpc4_q, dpc4_d;
  logic [31:0] dinst_q, dinst_d;
  logic        dvalid_q, dvalid_d;
  logic [31:0] hold_q, hold_d;
  logic        redirect;
  logic        load_inst;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;
  assign redirect = dvalid_q & wpcir & (pcsource != 2'b00);

  always_comb begin
    target = pc_plus4;
    unique case (pcsource)
      2'b01:   target = bpc;
      2'b10:   target = rpc;
      2'b11:   target = jpc;
      default: target = pc_plus4;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    dpc4_d    = dpc4_q;
    dinst_d   = dinst_q;
    dvalid_d  = dvalid_q;
    hold_d    = hold_q;
    load_inst = 1'b0;
    if (redirect) begin
      // Squash whatever was fetched; an unacked request must still drain.
      pc_d     = target;
      dinst_d  = NOP_INST;
      dvalid_d = 1'b0;
      state_d  = ((state_q != S_HOLD) && !imem_ack) ? S_DROP : S_REQ;
    end else begin
      unique case (state_q)
        S_REQ, S_WAIT: begin
          if (imem_ack) begin
            if (wpcir) begin
              dinst_d   = imem_rdata;
              dpc4_d    = pc_plus4;
              dvalid_d  = 1'b1;
              pc_d      = pc_plus4;
              load_inst = 1'b1;
              state_d   = S_REQ;
            end else begin
              hold_d  = imem_rdata;
              state_d = S_HOLD;
            end
          end else begin
            state_d = S_WAIT;
            if (wpcir) begin
              dinst_d  = NOP_INST;
              dvalid_d = 1'b0;
            end
          end
        end
        S_HOLD: begin
          if (wpcir) begin
            dinst_d   = hold_q;
            dpc4_d    = pc_plus4;
            dvalid_d  = 1'b1;
            pc_d      = pc_plus4;
            load_inst = 1'b1;
            state_d   = S_REQ;
          end
        end
        S_DROP: begin
          if (wpcir) begin
            dinst_d  = NOP_INST;
            dvalid_d = 1'b0;
          end
          if (imem_ack) state_d = S_REQ;
        end
      endcase
    end
    // Every entry into S_REQ starts a new fetch of the (possibly new) pc.
    addr_d = (state_d == S_REQ) ? pc_d : addr_q;
    req_d  = (state_d != S_HOLD);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_REQ;
      req_q    <= 1'b1;
      pc_q     <= RESET_PC;
      addr_q   <= RESET_PC;
      dpc4_q   <= 32'h0;
      dinst_q  <= NOP_INST;
      dvalid_q <= 1'b0;
      hold_q   <= NOP_INST;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      dpc4_q   <= dpc4_d;
      dinst_q  <= dinst_d;
      dvalid_q <= dvalid_d;
      hold_q   <= hold_d;
    end
  end

`ifdef PIPE_IF_PERF_EN
  logic [31:0] fetched_q, stall_q, squash_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      fetched_q <= 32'h0;
      stall_q   <= 32'h0;
      squash_q  <= 32'h0;
    end else begin
      if (load_inst) fetched_q <= fetched_q + 32'd1;
      if (!wpcir || (state_q == S_WAIT) || (state_q == S_DROP)) stall_q <= stall_q + 32'd1;
      if (redirect) squash_q <= squash_q + 32'd1;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_stall   = stall_q;
  assign perf_squash  = squash_q;
`endif

  // The request is abandoned combinationally while reset is held.
  assign imem_req   = req_q & ~reset;
  assign imem_addr  = addr_q;
  assign pc         = pc_q;
  assign dpc4       = dpc4_q;
  assign dinst      = dinst_q;
  assign dvalid     = dvalid_q;
  assign fetch_busy = ~reset & ((state_q == S_WAIT) || (state_q == S_DROP) ||
                                ((state_q == S_REQ) && !imem_ack));
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_pipe_if_stage.sv
// Bench for pipe_if_stage: variable-latency memory model, program-order
// scoreboard of delivered instructions, directed timing checks, random phase.
module tb_pipe_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  logic        clock;
  logic        reset;
  logic        wpcir;
  logic [1:0]  pcsource;
  logic [31:0] bpc, rpc, jpc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc, dpc4, dinst;
  logic        dvalid;
  logic        fetch_busy;
  logic [1:0]  dbg_state;

  pipe_if_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .clock(clock), .reset(reset), .wpcir(wpcir), .pcsource(pcsource),
    .bpc(bpc), .rpc(rpc), .jpc(jpc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pc(pc), .dpc4(dpc4), .dinst(dinst), .dvalid(dvalid), .fetch_busy(fetch_busy),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- bookkeeping ----------------
  int n_chk  = 0;
  int n_fail = 0;
  int n_pops = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory contents: a bijective scramble so every address is distinct and nonzero at 0.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] + 16'h1357};
  endfunction

  // ---------------- memory model ----------------
  int          mem_lat = 0;   // <0: random 0..3 extra cycles
  bit          in_txn  = 0;
  int          rem     = 0;
  logic [31:0] lat_addr;

  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(negedge clock);
      #1;
      if (reset) begin
        chk("req_low_in_reset", {31'h0, imem_req}, 32'h0);
        in_txn     = 0;
        imem_ack   = 1'b1;  // stray ack that must be ignored
        imem_rdata = 32'hBAD0_0000 | ($urandom & 32'hFFFF);
      end else begin
        if (in_txn && imem_ack) in_txn = 0;
        if (!in_txn) begin
          if (imem_req) begin
            in_txn   = 1;
            lat_addr = imem_addr;
            rem      = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
          end
        end else begin
          chk("req_held", {31'h0, imem_req}, 32'h1);
          chk("addr_held", imem_addr, lat_addr);
          rem--;
        end
        imem_ack   = in_txn && (rem == 0);
        imem_rdata = imem_ack ? mem_word(lat_addr) : $urandom;
      end
    end
  end

  // ---------------- scoreboard: program-order reference ----------------
  logic [31:0] exp_q[$];
  logic [31:0] cur_addr = 32'h0;
  bit          in_id    = 0;

  // An instruction in IF/ID leaves on the first cycle wpcir=1; its successor
  // is the sequential word or the selected target.
  initial begin
    logic [31:0] nxt;
    forever begin
      @(posedge clock);
      if (reset) begin
        exp_q.delete();
        exp_q.push_back(RESET_PC);
        in_id = 0;
      end else if (in_id && wpcir) begin
        in_id = 0;
        case (pcsource)
          2'b01:   nxt = bpc;
          2'b10:   nxt = rpc;
          2'b11:   nxt = jpc;
          default: nxt = cur_addr + 32'd4;
        endcase
        exp_q.push_back(nxt);
      end
    end
  end

  // Monitor: whenever IF/ID was allowed to advance, it holds the next expected word or a bubble.
  initial begin
    logic        w, rs;
    logic [31:0] a;
    forever begin
      @(posedge clock);
      w  = wpcir;
      rs = reset;
      #1;
      if (!rs && w) begin
        if (dvalid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_inst", dpc4, 32'hFFFF_FFFF);
          end else begin
            a = exp_q.pop_front();
            chk("sb_dpc4", dpc4, a + 32'd4);
            chk("sb_dinst", dinst, mem_word(a));
            cur_addr = a;
            in_id    = 1;
            n_pops++;
          end
        end else begin
          chk("sb_bubble_nop", dinst, NOP_INST);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(negedge clock);
  endtask

  initial begin
    logic [31:0] r;
    int          pops_before;
    reset = 1'b1; wpcir = 1'b1; pcsource = 2'b00;
    bpc = 32'h0; rpc = 32'h0; jpc = 32'h0;
    mem_lat = 0;
    repeat (3) tick();
    chk("rst_pc", pc, RESET_PC);
    chk("rst_dpc4", dpc4, 32'h0);
    chk("rst_dinst", dinst, NOP_INST);
    chk("rst_dvalid", {31'h0, dvalid}, 32'h0);
    chk("rst_state", {30'h0, dbg_state}, 32'd0);
    reset = 1'b0;

    // zero-wait stream
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      chk("zw_addr", imem_addr, 32'(4 * i));
      if (i > 0) begin
        chk("zw_dvalid", {31'h0, dvalid}, 32'h1);
        chk("zw_dpc4", dpc4, 32'(4 * i));
      end
    end

    // three-cycle latency: two bubbles per fetch
    mem_lat = 2;
    for (int j = 1; j <= 9; j++) begin
      tick();
      chk("lat3_dvalid", {31'h0, dvalid}, (j % 3 == 0) ? 32'h1 : 32'h0);
      if (j % 3 == 0) chk("lat3_dpc4", dpc4, 32'(20 + 4 * (j / 3)));
      else            chk("lat3_nop", dinst, NOP_INST);
    end
    chk("lat3_pc", pc, 32'd32);
    chk("lat3_addr", imem_addr, 32'd32);

    // ack while stalled: buffer in S_HOLD
    mem_lat = 0;
    wpcir   = 1'b0;
    tick();
    chk("hold_pc", pc, 32'd32);
    chk("hold_req", {31'h0, imem_req}, 32'h0);
    chk("hold_state", {30'h0, dbg_state}, 32'd2);
    chk("hold_dpc4", dpc4, 32'd32);
    tick();
    chk("hold_pc2", pc, 32'd32);
    chk("hold_req2", {31'h0, imem_req}, 32'h0);
    wpcir = 1'b1;
    tick();
    chk("hold_release_dinst", dinst, mem_word(32'd32));
    chk("hold_release_dpc4", dpc4, 32'd36);
    chk("hold_release_pc", pc, 32'd36);

    // branch with same-cycle ack
    pcsource = 2'b01; bpc = 32'h100;
    tick();
    chk("br_dvalid", {31'h0, dvalid}, 32'h0);
    chk("br_dinst", dinst, NOP_INST);
    chk("br_pc", pc, 32'h100);
    chk("br_addr", imem_addr, 32'h100);
    pcsource = 2'b00;
    tick();
    chk("br_target_dinst", dinst, mem_word(32'h100));

    // jump while a slow fetch is outstanding
    mem_lat = 2; pcsource = 2'b11; jpc = 32'h40;
    tick();
    chk("jmp_pc", pc, 32'h40);
    chk("jmp_old_addr", imem_addr, 32'h104);
    chk("jmp_busy", {31'h0, fetch_busy}, 32'h1);
    chk("jmp_state", {30'h0, dbg_state}, 32'd3);
    pcsource = 2'b00;
    tick();
    chk("drop_busy", {31'h0, fetch_busy}, 32'h1);
    tick();
    chk("drop_new_addr", imem_addr, 32'h40);
    chk("drop_dvalid", {31'h0, dvalid}, 32'h0);
    repeat (3) tick();
    chk("jmp_target_dinst", dinst, mem_word(32'h40));
    chk("jmp_target_dvalid", {31'h0, dvalid}, 32'h1);

    // pc wrap
    mem_lat = 0; pcsource = 2'b11; jpc = 32'hFFFF_FFFC;
    tick();
    chk("wrap_pc0", pc, 32'hFFFF_FFFC);
    pcsource = 2'b00;
    tick();
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_dpc4", dpc4, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);

    // reset while waiting on the memory
    mem_lat = 3;
    tick();
    chk("wait_busy", {31'h0, fetch_busy}, 32'h1);
    reset = 1'b1;
    tick();
    chk("midrst_pc", pc, RESET_PC);
    chk("midrst_dvalid", {31'h0, dvalid}, 32'h0);
    chk("midrst_dinst", dinst, NOP_INST);
    chk("midrst_req", {31'h0, imem_req}, 32'h0);
    reset = 1'b0;

    // random traffic
    mem_lat = -1;
    pops_before = n_pops;
    for (int k = 0; k < 3000; k++) begin
      tick();
      reset = ($urandom_range(0, 499) == 0);
      wpcir = ($urandom_range(0, 99) < 70);
      pcsource = ($urandom_range(0, 99) < 30) ? 2'($urandom_range(1, 3)) : 2'b00;
      r = $urandom; bpc = {r[31:2], 2'b00};
      r = $urandom; rpc = {r[31:2], 2'b00};
      r = $urandom; jpc = {r[31:2], 2'b00};
    end
    reset = 1'b0; wpcir = 1'b1; pcsource = 2'b00;
    repeat (20) tick();
    chk("random_progress", {31'h0, (n_pops - pops_before) > 300}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_if_stage.md
Name: pipe_if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline.
- Holds the PC and selects the next PC from the ID-stage pcsource (PC+4 / branch / jr register / jump).
- Fetches from a variable-latency instruction memory over a req/ack handshake.
- Drives the IF/ID pipeline register consumed by the ID control unit and honours its stall (wpcir) and redirect signals.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0000, instruction word inserted into IF/ID as a bubble.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- wpcir  input  1  1 = pipeline may advance; 0 = load-use stall (PC and IF/ID hold).
- pcsource  input  2  00 PC+4, 01 bpc, 10 rpc, 11 jpc; produced by the ID control unit for the instruction in IF/ID.
- bpc  input  32  branch target.
- rpc  input  32  jr register target.
- jpc  input  32  jump target.
- imem_req  output  1  fetch request.
- imem_addr  output  32  fetch address.
- imem_ack  input  1  imem_rdata valid this cycle.
- imem_rdata  input  32  fetched instruction.
- pc  output  32  current fetch PC.
- dpc4  output  32  IF/ID PC+4.
- dinst  output  32  IF/ID instruction.
- dvalid  output  1  IF/ID holds a real instruction (0 = bubble).
- fetch_busy  output  1  a memory request is outstanding.

Behaviour:
- Reset (reset=1 at edge): pc=RESET_PC, dpc4=0, dinst=NOP_INST, dvalid=0, state=S_REQ, hold buffer empty. imem_req=0 while reset is high.
- States: S_REQ (issue fetch of pc), S_WAIT (awaiting ack), S_HOLD (instruction buffered, ID stalled), S_DROP (awaiting ack of a squashed fetch).
- Handshake:
  - imem_req=1 in S_REQ, S_WAIT and S_DROP.
  - imem_addr comes from a fetch-address register, latched from pc on entry to S_REQ and held until ack.
  - Ack may arrive in the same cycle as the first req (zero-wait memory).
  - req is deasserted the cycle after ack unless a new fetch starts.
- redirect = dvalid & wpcir & (pcsource != 00); target chosen by pcsource.
- S_REQ/S_WAIT, ack=1, no redirect:
  - wpcir=1: dinst<=imem_rdata, dpc4<=pc+4, dvalid<=1, pc<=pc+4, next S_REQ.
  - wpcir=0: hold_buf<=imem_rdata, IF/ID and pc unchanged, next S_HOLD.
- S_REQ/S_WAIT, ack=0, no redirect:
  - wpcir=1: IF/ID<=bubble (dinst=NOP_INST, dvalid=0, dpc4 unchanged); stay/enter S_WAIT.
  - wpcir=0: IF/ID unchanged.
- S_HOLD:
  - imem_req=0.
  - wpcir=0: all state held.
  - wpcir=1, no redirect: IF/ID<=hold_buf/pc+4, dvalid<=1, pc<=pc+4, next S_REQ.
- Redirect (any state):
  - pc<=target; IF/ID<=bubble; the fetched or buffered instruction is discarded.
  - Next state: S_DROP if a request is outstanding and ack=0 this cycle; otherwise S_REQ.
- S_DROP: req held on the old address; on ack, data is discarded and state goes to S_REQ (new pc). IF/ID bubbles meanwhile while wpcir=1.
- wpcir=0 suppresses redirect: the branch re-evaluates once the stall clears.
- pc+4 wraps modulo 2^32. pc is never modified while wpcir=0.
- fetch_busy=1 in S_WAIT and S_DROP, and in S_REQ while imem_req=1 and ack=0.
- Reset mid-fetch: state returns to S_REQ. Any ack for the abandoned request that arrives while reset is high is ignored. Memory must tolerate the abandoned request.

Optional Feature:
- Macro: PIPE_IF_PERF_EN.
- Defined:
  - Adds output perf_fetched [31:0]: increments when a real instruction enters IF/ID (dvalid loaded with 1).
  - Adds output perf_stall [31:0]: increments each cycle wpcir=0 or state is S_WAIT/S_DROP.
  - Adds output perf_squash [31:0]: increments per redirect.
  - All three are cleared by reset and wrap at 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Zero-wait memory (ack same cycle), wpcir=1, pcsource=00, RESET_PC=0 -> dpc4 = 4, 8, 12… on consecutive cycles, dvalid=1 from cycle 1, imem_addr 0, 4, 8….
- 3-cycle ack latency -> two bubble cycles (dvalid=0, dinst=NOP) per fetch; imem_addr held stable until ack.
- Ack arrives with wpcir=0 for 2 cycles -> S_HOLD, pc unchanged, imem_req=0; the buffered word appears in dinst on the first cycle after wpcir=1.
- dvalid=1, pcsource=01, bpc=0x100, ack same cycle -> fetched word discarded, dvalid=0, pc=0x100, next imem_addr=0x100.
- Redirect pcsource=11, jpc=0x40 while a 3-cycle fetch is outstanding -> S_DROP; late ack discarded (never reaches dinst); next request address 0x40.
- pc=0xFFFF_FFFC, sequential fetch -> next pc=0x0000_0000. reset asserted in S_WAIT -> pc=RESET_PC, dvalid=0 the next cycle.
